// File: rtl/data_mem_responder.sv
// Load/store data-memory responder: one request at a time, a fixed wait, then one response.
// Handles RV32I byte/halfword/word widths with sign/zero extension and per-lane store masking.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_access;
    logic [31:0] w_offset;
    logic [29:0] w_word_idx;
    logic [AW-1:0] w_idx;
    logic        w_range_err;
    logic        w_fn_err;
    logic        w_align_err;
    logic        w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_do_write;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_access = (r_state == ST_BUSY) && (r_cnt == 4'd0);

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign w_offset    = r_addr - BASE_ADDR;
    assign w_word_idx  = w_offset[31:2];
    assign w_idx       = w_word_idx[AW-1:0];
    assign w_range_err = ({2'b00, w_word_idx} >= 32'(DEPTH_WORDS));

    always_comb begin
        if (r_we)
            w_fn_err = r_funct3[2] || (r_funct3[1:0] == 2'b11);
        else
            w_fn_err = (r_funct3[1:0] == 2'b11) || (r_funct3 == 3'b110);
    end

    always_comb begin
        case (r_funct3[1:0])
            2'b01:   w_align_err = w_offset[0];
            2'b10:   w_align_err = (w_offset[1:0] != 2'b00);
            default: w_align_err = 1'b0;
        endcase
    end

    assign w_err      = w_fn_err || w_align_err || w_range_err;
    assign w_do_write = w_access && r_we && !w_err && !reset;

    // Store data is replicated across lanes; the byte enables pick the addressed ones.
    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_be     = 4'b0001 << w_offset[1:0];
                w_wlanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = w_offset[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [0:DEPTH_WORDS-1];

            always_ff @(posedge clk) begin
                if (w_do_write && w_be[gi])
                    r_mem[w_idx] <= w_wlanes[8*gi +: 8];
            end

            assign w_word[8*gi +: 8] = r_mem[w_idx];
        end
    endgenerate

    always_comb begin
        case (w_offset[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_offset[1] ? w_word[31:16] : w_word[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_cnt    <= 4'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= 4'(LATENCY - 1);
            end else if ((r_state == ST_BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (!w_err && !r_we) ? w_load_data : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_state_next = ST_BUSY;
            ST_BUSY: if (r_cnt == 4'd0) w_state_next = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

endmodule
